mem_bus_arbiter: RTL and testbench

- Shares one single-port memory/peripheral bus between two requesters of the min-SOPC core: the instruction-fetch port (i_*) and the data-access port (d_*).
- Grants one transaction at a time and drives registered slave outputs.
- Returns a one-cycle ack with read data to the owner, and raises per-master stall requests for the pipeline ctrl block.
- Bounds every transaction with a watchdog timeout.

---
 rtl/mem_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data access) arbiter for a single-port slave bus.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of data-first priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              s_ce,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;   // 0 = inst, 1 = data
  logic                last_reg, last_next;
  logic [7:0]          tcnt_reg, tcnt_next;
  logic                s_ce_reg, s_ce_next;
  logic                s_we_reg, s_we_next;
  logic [ADDR_W-1:0]   s_addr_reg, s_addr_next;
  logic [SEL_W-1:0]    s_sel_reg, s_sel_next;
  logic [DATA_W-1:0]   s_wdata_reg, s_wdata_next;
  logic                i_ack_reg, i_ack_next;
  logic                i_err_reg, i_err_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic                d_ack_reg, d_ack_next;
  logic                d_err_reg, d_err_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;

  logic                i_elig, d_elig, grant_data;
  logic [DATA_W-1:0]   done_rdata;
  logic                done_err, done;

  // A master whose ack is high this cycle is not eligible, so it cannot be re-granted on the same edge.
  assign i_elig = i_req & ~i_ack_reg;
  assign d_elig = d_req & ~d_ack_reg;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_data = d_elig & (~i_elig | ~last_reg);
`else
  assign grant_data = d_elig;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b0;
      tcnt_reg    <= '0;
      s_ce_reg    <= 1'b0;
      s_we_reg    <= 1'b0;
      s_addr_reg  <= '0;
      s_sel_reg   <= '0;
      s_wdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      i_err_reg   <= 1'b0;
      i_rdata_reg <= '0;
      d_ack_reg   <= 1'b0;
      d_err_reg   <= 1'b0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      tcnt_reg    <= tcnt_next;
      s_ce_reg    <= s_ce_next;
      s_we_reg    <= s_we_next;
      s_addr_reg  <= s_addr_next;
      s_sel_reg   <= s_sel_next;
      s_wdata_reg <= s_wdata_next;
      i_ack_reg   <= i_ack_next;
      i_err_reg   <= i_err_next;
      i_rdata_reg <= i_rdata_next;
      d_ack_reg   <= d_ack_next;
      d_err_reg   <= d_err_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    tcnt_next    = tcnt_reg;
    s_ce_next    = s_ce_reg;
    s_we_next    = s_we_reg;
    s_addr_next  = s_addr_reg;
    s_sel_next   = s_sel_reg;
    s_wdata_next = s_wdata_reg;
    i_ack_next   = 1'b0;
    i_err_next   = i_err_reg;
    i_rdata_next = i_rdata_reg;
    d_ack_next   = 1'b0;
    d_err_next   = d_err_reg;
    d_rdata_next = d_rdata_reg;
    done         = 1'b0;
    done_err     = 1'b0;
    done_rdata   = '0;

    case (state_reg)
      IDLE: begin
        if (i_elig | d_elig) begin
          state_next = BUSY;
          tcnt_next  = '0;
          owner_next = grant_data;
          last_next  = grant_data;
          s_ce_next  = 1'b1;
          if (grant_data) begin
            s_we_next    = d_we;
            s_addr_next  = d_addr;
            s_sel_next   = d_sel;
            s_wdata_next = d_wdata;
          end else begin
            s_we_next    = 1'b0;
            s_addr_next  = i_addr;
            s_sel_next   = '1;
            s_wdata_next = '0;
          end
        end
      end
      BUSY: begin
        if (s_ack) begin
          done       = 1'b1;
          done_rdata = s_we_reg ? '0 : s_rdata;
        end else if (tcnt_reg == TCNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Completion (normal or aborted) returns the bus to IDLE and acks only the owner.
    if (done) begin
      state_next = IDLE;
      s_ce_next  = 1'b0;
      s_we_next  = 1'b0;
      if (owner_reg) begin
        d_ack_next   = 1'b1;
        d_err_next   = done_err;
        d_rdata_next = done_rdata;
      end else begin
        i_ack_next   = 1'b1;
        i_err_next   = done_err;
        i_rdata_next = done_rdata;
      end
    end
  end

  assign i_ack   = i_ack_reg;
  assign i_err   = i_err_reg;
  assign i_rdata = i_rdata_reg;
  assign i_stall = i_req & ~i_ack_reg;
  assign d_ack   = d_ack_reg;
  assign d_err   = d_err_reg;
  assign d_rdata = d_rdata_reg;
  assign d_stall = d_req & ~d_ack_reg;
  assign s_ce    = s_ce_reg;
  assign s_we    = s_we_reg;
  assign s_addr  = s_addr_reg;
  assign s_sel   = s_sel_reg;
  assign s_wdata = s_wdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random
// masters/slave checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_ack, i_err, i_stall;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack, d_err, d_stall;
  logic [AW-1:0] d_addr;
  logic [SW-1:0] d_sel;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          s_ce, s_we, s_ack;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_wdata, s_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata), .d_stall(d_stall),
    .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one in-flight transfer, its age in cycles, per-master result registers.
  typedef struct {
    bit        m;
    bit [31:0] addr;
    bit        we;
    bit [3:0]  sel;
    bit [31:0] wdata;
  } txn_t;

  bit        mb_busy;
  bit        mb_last;
  int        mb_age;
  txn_t      mb_cur;
  bit        mb_ack[2];
  bit        mb_err[2];
  bit [31:0] mb_rdata[2];

  task automatic model_finish(input bit err, input bit [31:0] rd);
    mb_ack[mb_cur.m]   = 1'b1;
    mb_err[mb_cur.m]   = err;
    mb_rdata[mb_cur.m] = rd;
    mb_busy            = 1'b0;
  endtask

  task automatic model_step();
    bit ei, ed, w;
    if (rst === 1'b0) begin
      mb_busy = 0; mb_last = 0; mb_age = 0;
      for (int m = 0; m < 2; m++) begin
        mb_ack[m] = 0; mb_err[m] = 0; mb_rdata[m] = 0;
      end
    end else if (!mb_busy) begin
      ei = i_req && !mb_ack[0];
      ed = d_req && !mb_ack[1];
      mb_ack[0] = 0;
      mb_ack[1] = 0;
      if (ei || ed) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (ei && ed) ? !mb_last : ed;
`else
        w = ed;
`endif
        mb_cur.m = w;
        if (w) begin
          mb_cur.addr = d_addr; mb_cur.we = d_we; mb_cur.sel = d_sel; mb_cur.wdata = d_wdata;
        end else begin
          mb_cur.addr = i_addr; mb_cur.we = 0; mb_cur.sel = 4'hF; mb_cur.wdata = 0;
        end
        mb_busy = 1;
        mb_age  = 1;
        mb_last = w;
      end
    end else begin
      if (s_ack) model_finish(1'b0, mb_cur.we ? 32'h0 : s_rdata);
      else if (mb_age == TO) model_finish(1'b1, 32'h0);
      else mb_age++;
    end
  endtask

  task automatic compare();
    check("s_ce", s_ce, mb_busy);
    if (mb_busy) begin
      check("s_addr", s_addr, mb_cur.addr);
      check("s_we", s_we, mb_cur.we);
      check("s_sel", s_sel, mb_cur.sel);
      check("s_wdata", s_wdata, mb_cur.wdata);
    end
    check("i_ack", i_ack, mb_ack[0]);
    check("i_err", i_err, mb_err[0]);
    check("i_rdata", i_rdata, mb_rdata[0]);
    check("d_ack", d_ack, mb_ack[1]);
    check("d_err", d_err, mb_err[1]);
    check("d_rdata", d_rdata, mb_rdata[1]);
    check("i_stall", i_stall, i_req & ~mb_ack[0]);
    check("d_stall", d_stall, d_req & ~mb_ack[1]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  end

  // Slave: acks after a chosen number of cycles (fixed, or random with occasional no-ack).
  int        slave_delay = 1;
  bit [31:0] slave_data  = 32'h0;
  int        s_cnt = 0;
  int        s_target = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (s_ce === 1'b1) begin
        if (s_cnt == 0)
          s_target = (slave_delay >= 0) ? slave_delay :
                     (($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4)));
        s_ack = (s_cnt >= s_target);
        s_cnt++;
      end else begin
        s_cnt = 0;
        s_ack = 1'b0;
      end
      s_rdata = (slave_delay >= 0) ? slave_data : $urandom;
    end
  end

  task automatic wait_ack(input bit m, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((m ? d_ack : i_ack) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_ack: master %0d got no ack within %0d cycles, required one", m, budget);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b0; s_ack = 1'b0; s_rdata = '0;
    i_req = 0; i_addr = '0;
    d_req = 1; d_we = 0; d_addr = 32'h400; d_sel = 4'hF; d_wdata = '0;
    slave_delay = 1; slave_data = 32'h1111_2222;

    // Reset held two edges with a pending data request
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ce", s_ce, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_sel", s_sel, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_stall", d_stall, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release_grant", {s_ce, s_addr}, {1'b1, 32'h400});
    wait_ack(1, 40);
    check("first_d_rdata", d_rdata, 32'h1111_2222);
    d_req = 0;
    @(negedge clk);

    // Instruction read, slave acks 2 cycles after s_ce
    slave_data = 32'h3C01_1234;
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    check("inst_s_bus", {s_ce, s_we, s_sel, s_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    @(negedge clk);
    check("inst_ack_early", {i_ack, i_stall}, {1'b0, 1'b1});
    @(negedge clk);
    check("inst_ack", {i_ack, i_err, i_stall}, {1'b1, 1'b0, 1'b0});
    check("inst_rdata", i_rdata, 32'h3C01_1234);
    i_req = 0;
    @(negedge clk);
    check("inst_ack_pulse", i_ack, 0);
    check("inst_rdata_hold", i_rdata, 32'h3C01_1234);

    // Contention with last = inst: data first in both builds
    slave_data = 32'hA5A5_0001;
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    @(negedge clk);
    check("cont1_first", s_addr, 32'h200);
    wait_ack(1, 40);
    check("cont1_i_stall", i_stall, 1);
    d_req = 0;
    @(negedge clk);
    check("cont1_second", {s_ce, s_addr}, {1'b1, 32'h104});
    wait_ack(0, 40);
    i_req = 0;
    @(negedge clk);

    // Data alone so last = data, then contention again
    d_req = 1; d_addr = 32'h204;
    wait_ack(1, 40);
    d_req = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h108;
    d_req = 1; d_addr = 32'h208;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont2_first", s_addr, 32'h108);
    wait_ack(0, 40); i_req = 0;
    wait_ack(1, 40); d_req = 0;
`else
    check("cont2_first", s_addr, 32'h208);
    wait_ack(1, 40); d_req = 0;
    wait_ack(0, 40); i_req = 0;
`endif
    @(negedge clk);

    // Data write
    d_req = 1; d_we = 1; d_addr = 32'h300; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_s_bus", {s_we, s_sel, s_addr}, {1'b1, 4'b0011, 32'h300});
    check("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    wait_ack(1, 40);
    check("wr_ack", {d_rdata, d_err}, {32'h0, 1'b0});
    d_req = 0; d_we = 0; d_sel = 4'hF;
    @(negedge clk);

    // Timeout: slave never answers
    slave_delay = 1000;
    d_req = 1; d_addr = 32'h500;
    cnt = 0;
    @(negedge clk);
    while (s_ce === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_ce_cycles", cnt, 16);
    check("timeout_ack", {d_ack, d_err, d_rdata}, {1'b1, 1'b1, 32'h0});
    d_req = 0;
    @(negedge clk);
    check("timeout_after", {s_ce, d_ack, d_err}, {1'b0, 1'b0, 1'b1});

    // Reset on the second BUSY cycle drops the transfer silently
    i_req = 1; i_addr = 32'h600;
    @(negedge clk);
    check("rstmid_busy", s_ce, 1);
    rst = 0; i_req = 0;
    @(negedge clk);
    check("rstmid_ce", s_ce, 0);
    rst = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("rstmid_no_ack", i_ack, 0);
    end

    // Random traffic
    slave_delay = -1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (i_req && i_ack) i_req = 0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1;
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (d_req && d_ack) d_req = 0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1;
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_sel   = 4'($urandom_range(1, 15));
        d_wdata = $urandom;
      end
    end
    rst = 1; i_req = 0; d_req = 0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
